bnn_unit: RTL and testbench
===========================

BNN_UNIT -- requirements
Module: bnn_unit

Interface
REQ-001 SHALL have one clock and one reset; reset is synchronous and active-high.
REQ-002 SHALL have ports, one per line:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous active-high reset
- start  in  1  request to begin an operation
- BNNFuncE  in  2  operation select, sampled with start
- OpA  in  32  binary operand A (from RD1), sampled with start
- OpB  in  32  binary operand B (from RD2), sampled with start
- BNNResult  out  32  result driven into the Execute path-select mux
- busy  out  1  operation in progress; datapath stalls while high
- done  out  1  one-cycle pulse: BNNResult valid

Function
REQ-003 SHALL implement BNNFuncE encodings:
- 00 XNORPC: result = popcount(~(A^B)), range 0..32
- 01 ACC: acc = acc + popcount; result = new acc
- 10 CLR: acc = 0; result = 0
- 11 SIGN: result = 2*popcount - 32, 32-bit two's complement
REQ-004 SHALL use FSM states IDLE, COUNT, DONE:
- IDLE -> COUNT on start with func != CLR
- IDLE -> DONE on start with func == CLR
- COUNT -> DONE after 4 cycles
- DONE -> IDLE, or -> COUNT/DONE if start is present
REQ-005 SHALL latch OpA, OpB and BNNFuncE only on an accepted start; later input changes SHALL NOT affect the operation.
REQ-006 SHALL process 8 bits per COUNT cycle, byte 0 (bits 7:0) first, accumulating a 6-bit partial popcount.
REQ-007 Latency SHALL be: start at edge N gives done high in the cycle after edge N+5 for non-CLR, and after edge N+1 for CLR.
REQ-008 busy SHALL be high exactly while state == COUNT.
REQ-009 done SHALL be high exactly while state == DONE.
REQ-010 BNNResult SHALL update when entering DONE and SHALL hold until the next DONE entry.
REQ-011 start SHALL be ignored while busy; no queuing.
REQ-012 start in DONE SHALL be accepted that cycle (back-to-back operation).
REQ-013 acc SHALL be 32 bits and SHALL wrap modulo 2^32 without saturation or flag.
REQ-014 acc SHALL change only on ACC or CLR completion.

Reset
REQ-015 reset SHALL force, at the next edge:
- state = IDLE
- acc = 0
- BNNResult = 0
- busy = 0, done = 0
- latched operands and partial count = 0
REQ-016 reset mid-operation SHALL abort the operation with no done pulse and no acc update; reset SHALL take priority over start.

Structure
REQ-017 A shared package bnn_pkg SHALL hold:
- the bnn_func_t enum (XNORPC, ACC, CLR, SIGN)
- the bnn_state_t enum
- constants BNN_WIDTH=32, BNN_CHUNK=8, BNN_STEPS=4
REQ-018 A single combinational sub-module popcount8 (8-bit in, 4-bit count out) SHALL be instantiated once; all other logic is flat in bnn_unit.

Verification
REQ-019 XNORPC, A=B=0xFFFFFFFF, start at edge 0 -> busy high cycles 1-4, done in cycle 5, BNNResult=0x00000020.
REQ-020 XNORPC A=0x0F0F0F0F B=0 -> 0x00000010; SIGN A=0xFFFFFFFF B=0 -> 0xFFFFFFE0.
REQ-021 CLR, then ACC A=B=0x12345678 twice back-to-back (second start in DONE) -> results 0x20 then 0x40; CLR -> 0 with done one cycle after start.
REQ-022 start pulsed with different operands while busy -> ignored; result matches the first operands; exactly one done pulse.
REQ-023 ACC in progress, reset asserted in the second COUNT cycle -> next cycle busy=0, done=0, BNNResult=0, acc=0; a following XNORPC completes normally.
REQ-024 acc preloaded to 0xFFFFFFF0 via repeated ACC, then ACC with popcount 32 -> result 0x00000010 (wrap).

Source files
------------

// File: rtl/bnn_pkg.sv
// Shared types and constants for the binary neural-net XNOR/popcount unit.
package bnn_pkg;

  localparam int unsigned BNN_WIDTH = 32;
  localparam int unsigned BNN_CHUNK = 8;
  localparam int unsigned BNN_STEPS = 4;

  typedef enum logic [1:0] {
    FnXnorPc = 2'b00,
    FnAcc    = 2'b01,
    FnClr    = 2'b10,
    FnSign   = 2'b11
  } bnn_func_t;

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StCount = 2'b01,
    StDone  = 2'b10
  } bnn_state_t;

  // Maps a 0..32 match count onto a signed -32..+32 activation.
  function automatic logic [BNN_WIDTH-1:0] sign_of_count(input logic [5:0] pop);
    return ({{(BNN_WIDTH - 6){1'b0}}, pop} << 1) - BNN_WIDTH'(BNN_WIDTH);
  endfunction

endpackage

// File: rtl/popcount8.sv
// Combinational population count of one 8-bit chunk.
module popcount8 (
  input  logic [7:0] data_i,
  output logic [3:0] count_o
);

  always_comb begin
    count_o = '0;
    for (int i = 0; i < 8; i++) begin
      count_o = count_o + 4'(data_i[i]);
    end
  end

endmodule

// File: rtl/bnn_unit.sv
// Multi-cycle XNOR-popcount unit: one byte per COUNT cycle, with a wrapping 32-bit accumulator.
module bnn_unit
  import bnn_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [1:0]           BNNFuncE,
  input  logic [BNN_WIDTH-1:0] OpA,
  input  logic [BNN_WIDTH-1:0] OpB,
  output logic [BNN_WIDTH-1:0] BNNResult,
  output logic                 busy,
  output logic                 done
);

  bnn_state_t           state_q;
  bnn_func_t            func_q;
  logic [BNN_WIDTH-1:0] opa_q, opb_q, acc_q, result_q;
  logic [5:0]           partial_q;
  logic [1:0]           step_q;
  logic                 busy_q, done_q;

  logic [BNN_WIDTH-1:0] xnor_w;
  logic [7:0]           chunk;
  logic [3:0]           chunk_cnt;
  logic [5:0]           pop_total_d;
  logic [BNN_WIDTH-1:0] acc_d;

  assign xnor_w      = ~(opa_q ^ opb_q);
  assign chunk       = xnor_w[{step_q, 3'b000} +: BNN_CHUNK];
  assign pop_total_d = partial_q + 6'(chunk_cnt);
  assign acc_d       = acc_q + BNN_WIDTH'(pop_total_d);

  popcount8 u_popcount8 (
    .data_i  (chunk),
    .count_o (chunk_cnt)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      func_q    <= FnXnorPc;
      opa_q     <= '0;
      opb_q     <= '0;
      acc_q     <= '0;
      result_q  <= '0;
      partial_q <= '0;
      step_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      unique case (state_q)
        // DONE behaves like IDLE for start acceptance, giving back-to-back issue.
        StIdle, StDone: begin
          if (start) begin
            opa_q     <= OpA;
            opb_q     <= OpB;
            func_q    <= bnn_func_t'(BNNFuncE);
            partial_q <= '0;
            step_q    <= '0;
            if (BNNFuncE == FnClr) begin
              state_q  <= StDone;
              acc_q    <= '0;
              result_q <= '0;
              busy_q   <= 1'b0;
              done_q   <= 1'b1;
            end else begin
              state_q <= StCount;
              busy_q  <= 1'b1;
              done_q  <= 1'b0;
            end
          end else begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
          end
        end
        StCount: begin
          partial_q <= pop_total_d;
          step_q    <= step_q + 2'd1;
          if (step_q == 2'(BNN_STEPS - 1)) begin
            state_q <= StDone;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            unique case (func_q)
              FnXnorPc: result_q <= BNN_WIDTH'(pop_total_d);
              FnAcc: begin
                acc_q    <= acc_d;
                result_q <= acc_d;
              end
              FnSign:  result_q <= sign_of_count(pop_total_d);
              default: result_q <= result_q;
            endcase
          end
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign BNNResult = result_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_bnn_unit.sv
// Randomized self-checking bench for bnn_unit against a behavioural popcount/accumulator model.
module tb_bnn_unit;

  localparam logic [1:0] F_XNOR = 2'b00;
  localparam logic [1:0] F_ACC  = 2'b01;
  localparam logic [1:0] F_CLR  = 2'b10;
  localparam logic [1:0] F_SIGN = 2'b11;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  BNNFuncE;
  logic [31:0] OpA, OpB, BNNResult;
  logic        busy, done;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  logic [31:0] m_acc;

  always #5 clk = ~clk;

  bnn_unit dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .BNNFuncE  (BNNFuncE),
    .OpA       (OpA),
    .OpB       (OpB),
    .BNNResult (BNNResult),
    .busy      (busy),
    .done      (done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference: count matching bit positions, then apply the operation to the model accumulator.
  function automatic logic [31:0] model(input logic [1:0] f, input logic [31:0] a,
                                        input logic [31:0] b);
    int p;
    p = $countones(~(a ^ b));
    case (f)
      F_XNOR: model = 32'(p);
      F_ACC: begin
        m_acc = m_acc + 32'(p);
        model = m_acc;
      end
      F_CLR: begin
        m_acc = '0;
        model = '0;
      end
      default: model = 32'(2 * p - 32);
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one operation; returns in the cycle where done is seen (or the bound expires).
  task automatic run_op(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b,
                        input bit noise);
    logic [31:0] exp;
    int n;
    exp = model(f, a, b);
    start = 1'b1;
    BNNFuncE = f;
    OpA = a;
    OpB = b;
    tick();
    start = 1'b0;
    n = 0;
    while (done !== 1'b1 && n < 8) begin
      check("busy_in_count", 32'(busy), 32'd1);
      if (noise) begin
        OpA = $urandom;
        OpB = $urandom;
        BNNFuncE = 2'($urandom_range(0, 3));
        start = (n == 1);
      end
      tick();
      n++;
    end
    start = 1'b0;
    check("latency", 32'(n), (f == F_CLR) ? 32'd0 : 32'd4);
    check("busy_at_done", 32'(busy), 32'd0);
    check("result", BNNResult, exp);
  endtask

  // Idle cycle after a completion: done must have dropped and the result must hold.
  task automatic idle_check();
    logic [31:0] held;
    held = BNNResult;
    tick();
    check("done_single_pulse", 32'(done), 32'd0);
    check("result_hold", BNNResult, held);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] a, b;
    logic [1:0]  f;
    reset = 1'b1;
    start = 1'b0;
    BNNFuncE = '0;
    OpA = '0;
    OpB = '0;
    m_acc = '0;
    tick();
    tick();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_result", BNNResult, 32'd0);
    reset = 1'b0;
    tick();

    // Directed vectors.
    run_op(F_XNOR, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    check("xnor_all_ones", BNNResult, 32'h0000_0020);
    idle_check();
    run_op(F_XNOR, 32'h0F0F_0F0F, 32'h0, 1'b0);
    check("xnor_half", BNNResult, 32'h0000_0010);
    idle_check();
    run_op(F_SIGN, 32'hFFFF_FFFF, 32'h0, 1'b0);
    check("sign_min", BNNResult, 32'hFFFF_FFE0);
    idle_check();

    // CLR, two back-to-back ACCs, CLR.
    run_op(F_CLR, 32'h0, 32'h0, 1'b0);
    run_op(F_ACC, 32'h1234_5678, 32'h1234_5678, 1'b0);
    check("acc_first", BNNResult, 32'h0000_0020);
    run_op(F_ACC, 32'h1234_5678, 32'h1234_5678, 1'b0);
    check("acc_second", BNNResult, 32'h0000_0040);
    run_op(F_CLR, 32'h0, 32'h0, 1'b0);
    check("clr_result", BNNResult, 32'h0);
    idle_check();

    // Start pulsed with other operands while busy must be ignored.
    run_op(F_XNOR, 32'hA5A5_0000, 32'hA5A5_FFFF, 1'b1);
    check("ignore_busy_start", BNNResult, 32'h0000_0010);
    idle_check();

    // Reset in the second COUNT cycle of an ACC.
    start = 1'b1;
    BNNFuncE = F_ACC;
    OpA = 32'hFFFF_FFFF;
    OpB = 32'hFFFF_FFFF;
    tick();
    start = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    m_acc = '0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_result", BNNResult, 32'd0);
    tick();
    check("abort_no_late_done", 32'(done), 32'd0);
    run_op(F_XNOR, 32'h0000_00FF, 32'h0, 1'b0);
    run_op(F_ACC, 32'h0, 32'h0, 1'b0);
    check("acc_zero_after_reset", BNNResult, 32'h0000_0020);
    idle_check();

    // Accumulator wrap from 0xFFFFFFF0.
    force dut.acc_q = 32'hFFFF_FFF0;
    tick();
    release dut.acc_q;
    m_acc = 32'hFFFF_FFF0;
    run_op(F_ACC, 32'h5555_AAAA, 32'h5555_AAAA, 1'b0);
    check("acc_wrap", BNNResult, 32'h0000_0010);
    idle_check();

    // Randomized operations with random gaps, back-to-back issue and busy-time noise.
    for (int i = 0; i < 60; i++) begin
      f = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 3))
        0:       begin a = $urandom; b = a ^ (32'h1 << $urandom_range(0, 31)); end
        1:       begin a = $urandom; b = ~a; end
        default: begin a = $urandom; b = $urandom; end
      endcase
      run_op(f, a, b, 1'($urandom_range(0, 1)));
      for (int g = $urandom_range(0, 2); g > 0; g--) idle_check();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
